// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, initial chaining value, word-wise add and FSM states.
// Imported by the multi-context top, context table and compression unit.
package sha1_pkg;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hEFCDAB89;
    localparam logic [31:0] IV_C = 32'h98BADCFE;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam logic [31:0] IV_E = 32'hC3D2E1F0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    localparam sha1_state_t SHA1_IV = '{
        a: IV_A, b: IV_B, c: IV_C, d: IV_D, e: IV_E
    };

    function automatic sha1_state_t sha1_add(
        sha1_state_t x,
        sha1_state_t y
    );
        sha1_state_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CORE,
        SEND
    } mc_state_t;

endpackage

// File: rtl/sha1_mc_if.sv
// Block-in / digest-out stream bundle of the multi-context SHA-1 top.
// slave: the hasher side; master: the block source and digest sink side.
interface sha1_mc_if #(
    parameter int ID_W = 2
);
    logic            o_tready;
    logic            i_tvalid;
    logic [511:0]    i_tdata;
    logic [ID_W-1:0] i_tid;
    logic            i_tlast;
    logic            i_sha_tready;
    logic            o_sha_tvalid;
    logic [159:0]    o_sha_tdata;
    logic [ID_W-1:0] o_sha_tid;

    modport slave (
        input  i_tvalid, i_tdata, i_tid, i_tlast, i_sha_tready,
        output o_tready, o_sha_tvalid, o_sha_tdata, o_sha_tid
    );

    modport master (
        output i_tvalid, i_tdata, i_tid, i_tlast, i_sha_tready,
        input  o_tready, o_sha_tvalid, o_sha_tdata, o_sha_tid
    );
endinterface

// File: rtl/sha1_ctx_table.sv
// Per-context chaining values plus busy flags for suspended messages.
// Ports: one write port (data + busy bit), one combinational read port, busy vector.
module sha1_ctx_table
    import sha1_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ID_W-1:0]   wr_idx,
    input  sha1_state_t       wr_data,
    input  logic              wr_busy,
    input  logic [ID_W-1:0]   rd_idx,
    output sha1_state_t       rd_data,
    output logic              rd_busy,
    output logic [NUM_CTX-1:0] busy
);

    sha1_state_t tbl [NUM_CTX];

    // Chain values need no reset: a clear busy bit forces the IV.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CTX; i++) begin
            if (wr_en && wr_idx == ID_W'(i)) begin
                tbl[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (wr_en && wr_idx == ID_W'(i)) begin
                    busy[i] <= wr_busy;
                end
            end
        end
    end

    // Out-of-range indices read as not busy.
    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (rd_idx == ID_W'(i)) begin
                rd_data = tbl[i];
                rd_busy = busy[i];
            end
        end
    end

endmodule

// File: rtl/sha1_unit.sv
// Iterative SHA-1 compression core, one round per cycle (latency 80).
// Ports: i_valid/o_ready block in, o_valid/i_ready result out; o_hash has no feed-forward.
module sha1_unit
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [511:0] i_block,
    input  sha1_state_t  i_chain,
    output logic         o_valid,
    input  logic         i_ready,
    output sha1_state_t  o_hash
);

    logic [31:0] w [16];
    sha1_state_t st;
    logic [6:0]  cnt;
    logic        busy;
    logic        vld;

    logic [31:0] f;
    logic [31:0] k;
    logic [31:0] tmp;
    logic [31:0] wx;
    logic [31:0] w_new;

    always_comb begin
        f = st.b ^ st.c ^ st.d;
        k = 32'hCA62C1D6;
        if (cnt < 7'd20) begin
            f = (st.b & st.c) | (~st.b & st.d);
            k = 32'h5A827999;
        end else if (cnt < 7'd40) begin
            k = 32'h6ED9EBA1;
        end else if (cnt < 7'd60) begin
            f = (st.b & st.c) | (st.b & st.d) | (st.c & st.d);
            k = 32'h8F1BBCDC;
        end
        tmp   = {st.a[26:0], st.a[31:27]} + f + st.e + k + w[0];
        wx    = w[13] ^ w[8] ^ w[2] ^ w[0];
        w_new = {wx[30:0], wx[31]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            vld  <= 1'b0;
            cnt  <= '0;
            st   <= '0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else if (!busy && i_valid) begin
            busy <= 1'b1;
            cnt  <= '0;
            st   <= i_chain;
            for (int i = 0; i < 16; i++) begin
                w[i] <= i_block[511-32*i -: 32];
            end
        end else if (busy && !vld) begin
            // w[] is a sliding 16-word window of the message schedule
            st <= '{
                a: tmp,
                b: st.a,
                c: {st.b[1:0], st.b[31:2]},
                d: st.c,
                e: st.d
            };
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i+1];
            end
            w[15] <= w_new;
            if (cnt == 7'd79) begin
                vld <= 1'b1;
            end else begin
                cnt <= cnt + 7'd1;
            end
        end else if (vld && i_ready) begin
            vld  <= 1'b0;
            busy <= 1'b0;
        end
    end

    assign o_ready = !busy;
    assign o_valid = vld;
    assign o_hash  = st;

endmodule

// File: rtl/sha1_mc_top.sv
// Multi-context SHA-1: interleaved tagged blocks in, per-context digests out.
// Ports: clk, reset_n, bus (sha1_mc_if.slave), o_ctx_busy, o_bad_tid.
module sha1_mc_top
    import sha1_pkg::*;
#(
    parameter int NUM_CTX = 4,
    localparam int ID_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    sha1_mc_if.slave           bus,
    output logic [NUM_CTX-1:0] o_ctx_busy,
    output logic               o_bad_tid
);

    mc_state_t   state;
    logic        rdy_q;
    logic [ID_W-1:0] tid_q;
    logic        last_q;
    sha1_state_t chain_q;

    logic        unit_rdy;
    logic        unit_vld;
    logic        unit_in_vld;
    sha1_state_t unit_out;
    sha1_state_t rd_data;
    logic        rd_busy;
    sha1_state_t chain_in;
    sha1_state_t sum;
    logic        tid_ok;
    logic        hs;
    logic        wr_en;

    assign tid_ok      = 32'(bus.i_tid) < NUM_CTX;
    assign bus.o_tready = rdy_q && unit_rdy;
    assign hs          = bus.i_tvalid && bus.o_tready;
    assign unit_in_vld = hs && tid_ok;
    assign chain_in    = rd_busy ? rd_data : SHA1_IV;
    assign sum         = sha1_add(chain_q, unit_out);
    assign wr_en       = (state == WAIT_CORE) && unit_vld;

    sha1_ctx_table #(
        .NUM_CTX (NUM_CTX),
        .ID_W    (ID_W)
    ) u_tbl (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_idx  (tid_q),
        .wr_data (sum),
        .wr_busy (!last_q),
        .rd_idx  (bus.i_tid),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .busy    (o_ctx_busy)
    );

    sha1_unit u_unit (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (unit_in_vld),
        .o_ready (unit_rdy),
        .i_block (bus.i_tdata),
        .i_chain (chain_in),
        .o_valid (unit_vld),
        .i_ready (state == WAIT_CORE),
        .o_hash  (unit_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rdy_q            <= 1'b0;
            tid_q            <= '0;
            last_q           <= 1'b0;
            chain_q          <= '0;
            o_bad_tid        <= 1'b0;
            bus.o_sha_tvalid <= 1'b0;
            bus.o_sha_tdata  <= '0;
            bus.o_sha_tid    <= '0;
        end else begin
            o_bad_tid <= 1'b0;
            unique case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (hs && tid_ok) begin
                        tid_q   <= bus.i_tid;
                        last_q  <= bus.i_tlast;
                        chain_q <= chain_in;
                        rdy_q   <= 1'b0;
                        state   <= WAIT_CORE;
                    end else if (hs) begin
                        o_bad_tid <= 1'b1;
                    end
                end
                WAIT_CORE: begin
                    if (unit_vld) begin
                        if (last_q) begin
                            bus.o_sha_tvalid <= 1'b1;
                            bus.o_sha_tdata  <= sum;
                            bus.o_sha_tid    <= tid_q;
                            state            <= SEND;
                        end else begin
                            rdy_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                SEND: begin
                    if (bus.i_sha_tready) begin
                        bus.o_sha_tvalid <= 1'b0;
                        rdy_q            <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_mc_top.sv
// Directed vectors for the multi-context SHA-1 top (NUM_CTX 4 and 3).
// Known-answer digests, interleaving, back-pressure, bad tid and reset.
module tb_sha1_mc_top;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sha1_mc_if #(.ID_W(2)) bus4 ();
    sha1_mc_if #(.ID_W(2)) bus3 ();
    logic [3:0] busy4;
    logic [2:0] busy3;
    logic       bad4;
    logic       bad3;

    sha1_mc_top #(.NUM_CTX(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus4),
        .o_ctx_busy (busy4),
        .o_bad_tid  (bad4)
    );

    sha1_mc_top #(.NUM_CTX(3)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus3),
        .o_ctx_busy (busy3),
        .o_bad_tid  (bad3)
    );

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_M1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_M2 = {480'h0, 32'h1c0};
    localparam logic [159:0] DIG_ABC =
        160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMPTY =
        160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_M =
        160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    typedef struct {
        logic [1:0]   tid;
        logic         last;
        logic [511:0] blk;
        logic [159:0] dig;
        logic [3:0]   busy;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;
    int bad_cnt = 0;

    always @(negedge clk) begin
        if (bad3) bad_cnt++;
    end

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send4(input logic [1:0] tid, input logic last,
                         input logic [511:0] blk);
        int n = 0;
        while (!bus4.o_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {159'h0, bus4.o_tready}, 160'h1);
        bus4.i_tvalid = 1'b1;
        bus4.i_tid    = tid;
        bus4.i_tlast  = last;
        bus4.i_tdata  = blk;
        @(negedge clk);
        bus4.i_tvalid = 1'b0;
    endtask

    task automatic wait_dig4(output int lat);
        lat = 0;
        while (!bus4.o_sha_tvalid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("dig_valid", {159'h0, bus4.o_sha_tvalid}, 160'h1);
    endtask

    task automatic wait_rdy4();
        int n = 0;
        while (!bus4.o_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_back", {159'h0, bus4.o_tready}, 160'h1);
    endtask

    task automatic release4();
        bus4.i_sha_tready = 1'b1;
        @(negedge clk);
        bus4.i_sha_tready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int vcnt;
        vecs[0] = '{2'd2, 1'b1, BLK_ABC,   DIG_ABC,   4'b0000};
        vecs[1] = '{2'd0, 1'b1, BLK_EMPTY, DIG_EMPTY, 4'b0000};
        vecs[2] = '{2'd0, 1'b0, BLK_M1,    160'h0,    4'b0001};
        vecs[3] = '{2'd1, 1'b1, BLK_ABC,   DIG_ABC,   4'b0001};
        vecs[4] = '{2'd0, 1'b1, BLK_M2,    DIG_M,     4'b0000};

        bus4.i_tvalid = 0; bus4.i_tdata = '0; bus4.i_tid = '0;
        bus4.i_tlast = 0;  bus4.i_sha_tready = 0;
        bus3.i_tvalid = 0; bus3.i_tdata = '0; bus3.i_tid = '0;
        bus3.i_tlast = 0;  bus3.i_sha_tready = 1;

        repeat (3) @(negedge clk);
        chk("rst_tready", {159'h0, bus4.o_tready}, 160'h0);
        chk("rst_valid", {159'h0, bus4.o_sha_tvalid}, 160'h0);
        chk("rst_tdata", bus4.o_sha_tdata, 160'h0);
        chk("rst_tid", {158'h0, bus4.o_sha_tid}, 160'h0);
        chk("rst_busy", {156'h0, busy4}, 160'h0);
        chk("rst_bad", {159'h0, bad4}, 160'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send4(vecs[i].tid, vecs[i].last, vecs[i].blk);
            if (vecs[i].last) begin
                wait_dig4(lat);
                if (i == 0) chk("latency", 160'(lat), 160'd81);
                chk($sformatf("v%0d_dig", i), bus4.o_sha_tdata, vecs[i].dig);
                chk($sformatf("v%0d_tid", i), {158'h0, bus4.o_sha_tid},
                    {158'h0, vecs[i].tid});
                chk($sformatf("v%0d_busy", i), {156'h0, busy4},
                    {156'h0, vecs[i].busy});
                release4();
            end else begin
                wait_rdy4();
                chk($sformatf("v%0d_nodig", i),
                    {159'h0, bus4.o_sha_tvalid}, 160'h0);
                chk($sformatf("v%0d_busy", i), {156'h0, busy4},
                    {156'h0, vecs[i].busy});
            end
        end

        send4(2'd3, 1'b1, BLK_ABC);
        wait_dig4(lat);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {159'h0, bus4.o_sha_tvalid}, 160'h1);
            chk("hold_data", bus4.o_sha_tdata, DIG_ABC);
            chk("hold_tid", {158'h0, bus4.o_sha_tid}, 160'h3);
            chk("hold_tready", {159'h0, bus4.o_tready}, 160'h0);
            @(negedge clk);
        end
        release4();
        chk("rel_valid", {159'h0, bus4.o_sha_tvalid}, 160'h0);
        chk("rel_tready", {159'h0, bus4.o_tready}, 160'h1);

        vcnt = 0;
        while (!bus3.o_tready && vcnt < 300) begin
            @(negedge clk);
            vcnt++;
        end
        bus3.i_tvalid = 1; bus3.i_tid = 2'd0;
        bus3.i_tlast = 0;  bus3.i_tdata = BLK_M1;
        @(negedge clk);
        bus3.i_tvalid = 0;
        vcnt = 0;
        while (!bus3.o_tready && vcnt < 300) begin
            @(negedge clk);
            vcnt++;
        end
        chk("c3_busy", {157'h0, busy3}, 160'h1);
        bus3.i_tvalid = 1; bus3.i_tid = 2'd3;
        bus3.i_tlast = 1;  bus3.i_tdata = BLK_ABC;
        @(negedge clk);
        bus3.i_tvalid = 0;
        chk("c3_bad_hi", {159'h0, bad3}, 160'h1);
        chk("c3_still_rdy", {159'h0, bus3.o_tready}, 160'h1);
        @(negedge clk);
        chk("c3_bad_lo", {159'h0, bad3}, 160'h0);
        vcnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus3.o_sha_tvalid) vcnt++;
            @(negedge clk);
        end
        chk("c3_nodig", 160'(vcnt), 160'h0);
        chk("c3_busy_kept", {157'h0, busy3}, 160'h1);
        chk("c3_bad_count", 160'(bad_cnt), 160'h1);

        send4(2'd0, 1'b0, BLK_M1);
        wait_rdy4();
        chk("r_busy_pre", {156'h0, busy4}, 160'h1);
        send4(2'd0, 1'b1, BLK_M2);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("r_busy_rst", {156'h0, busy4}, 160'h0);
        chk("r_valid_rst", {159'h0, bus4.o_sha_tvalid}, 160'h0);
        reset_n = 1'b1;
        @(negedge clk);
        send4(2'd0, 1'b1, BLK_ABC);
        wait_dig4(lat);
        chk("r_lat", 160'(lat), 160'd81);
        chk("r_dig", bus4.o_sha_tdata, DIG_ABC);
        chk("r_tid", {158'h0, bus4.o_sha_tid}, 160'h0);
        release4();
        chk("r_busy_end", {156'h0, busy4}, 160'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
